sram_ctrl: RTL and testbench
============================

# sram_ctrl

Synchronous controller that turns single-cycle host requests into correctly sequenced cycles on an asynchronous SRAM bus: active-low chip select, output enable and write enable, plus a shared tri-state data bus. It sits between the CPU/bus fabric and the `sram` model or a real part. Data width, address width and read/write wait states are parameters. Strobe timing is generated by an internal state machine, so callers never drive SRAM pins directly.

## Interface
- `DATA_WIDTH`, 16: width of the host data and the SRAM data bus.
- `ADDR_WIDTH`, 16: width of the host address and the SRAM address.
- `READ_WAIT`, 2: number of cycles `sramNotOE` is held low per read; must be ≥1.
- `WRITE_SETUP`, 1: cycles with address and data valid before `sramNotWE` falls; must be ≥1.
- `WRITE_PULSE`, 2: cycles `sramNotWE` is held low; must be ≥1.
- `WRITE_HOLD`, 1: cycles with address and data held after `sramNotWE` rises; must be ≥1.

Ports:
- `clock` in 1: single clock; all logic updates on the rising edge.
- `notReset` in 1: synchronous, active-low reset.
- `req` in 1: request strobe, sampled only in IDLE.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in ADDR_WIDTH: request address; sampled with `req`.
- `wdata` in DATA_WIDTH: write data; sampled with `req`.
- `rdata` out DATA_WIDTH: read result; valid from the `ack` cycle until the next read completes.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high while a transaction is in progress, i.e. in any state other than IDLE.
- `sramAddr` out ADDR_WIDTH: SRAM address.
- `sramData` inout DATA_WIDTH: SRAM data bus; high-impedance unless the controller is writing.
- `sramNotCS`, `sramNotOE`, `sramNotWE` out 1 each: active-low SRAM strobes.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. A single down-counter, sized for the largest wait parameter, times each state.
- **IDLE**
  - All strobes are 1 and `sramData` is released.
  - On `req`=1, latch `addr`, `we` and `wdata`.
  - Go to RD if `we`=0, or to WR_SETUP if `we`=1.
- **RD**, for READ_WAIT cycles
  - `sramNotCS`=0 and `sramNotOE`=0; the bus is released.
  - On the final edge, capture `sramData` into `rdata` and go to IDLE.
- **WR_SETUP**, for WRITE_SETUP cycles
  - `sramNotCS`=0; `sramData` is driven with the latched data; `sramNotWE`=1.
- **WR_PULSE**, for WRITE_PULSE cycles
  - As WR_SETUP, but with `sramNotWE`=0.
- **WR_HOLD**, for WRITE_HOLD cycles
  - As WR_SETUP; then go to IDLE.
- **Completion**
  - Every completed transaction returns to IDLE with `ack`=1 for exactly that IDLE cycle.
  - A `req` in the ack cycle is accepted, so back-to-back transactions are allowed.
- **Bus rules**
  - `sramNotOE`=0 and a driven `sramData` never coincide.
  - Every transaction passes through at least one IDLE cycle, which guarantees a released-bus gap on read/write turnaround.
  - `sramNotWE` is low only in WR_PULSE.
  - `sramAddr` and the driven data are stable across the whole transaction.
- **Requests while busy**: `req`, `we`, `addr` and `wdata` are ignored outside IDLE. Nothing is queued; the host waits for `ack`.
- **Reset**
  - `notReset`=0 at any edge forces IDLE, even mid-transaction.
  - Reset values: all strobes 1, `sramData` released, `sramAddr`=0, `rdata`=0, `ack`=0, `busy`=0.
  - An interrupted write leaves the SRAM location undefined, and no `ack` is issued.

## Timing
- All outputs, including the strobes and the data-bus enable, are registered, so strobes are glitch-free.
- Cycle numbering: `req` is high in cycle 0 and sampled on the edge ending cycle 0.
- **Read**
  - `sramNotOE` is low in cycles 1..READ_WAIT.
  - `rdata` and `ack` are valid in cycle READ_WAIT+1.
  - Defaults: ack in cycle 3.
- **Write**
  - Setup cycles: 1..S.
  - `sramNotWE` low: cycles S+1..S+P.
  - Hold cycles: S+P+1..S+P+H.
  - `ack` in cycle S+P+H+1.
  - Defaults: `sramNotWE` low in cycles 2–3, ack in cycle 5.
- **Throughput**: one read per READ_WAIT+1 cycles; one write per S+P+H+1 cycles.
- **SRAM access time**: the SRAM's output-enable/address access time must be under READ_WAIT clock periods.

## Test plan
Bench configuration: DATA_WIDTH=16, ADDR_WIDTH=8, defaults elsewhere, with the `sram` model preloaded from a MEMFILE.

- **Reset**: hold `notReset`=0 for 2 cycles -> all strobes 1, `sramData`=z, `ack`/`busy`/`rdata`=0.
- **Single write**: write 0x1234 to address 0x03 -> `sramNotWE` low only in cycles 2–3; `sramData` driven in cycles 1–4; `ack` in cycle 5; `sramNotOE` stays 1.
- **Readback**:
  - Read 0x03 -> `ack` in cycle 3 with `rdata`=0x1234.
  - Read 0x00 -> `rdata` equals the MEMFILE word at address 0.
- **Sweep**: write address^0xA5A5 to addresses 0x03..0x0A back-to-back (`req` issued in each ack cycle), then read them all back -> every word matches, with no cycle where `sramNotOE`=0 while the bus is driven.
- **Ignored request**: pulse `req` as a read of 0x05 in cycle 2 of a write -> exactly one `ack`, and no RD state follows.
- **Reset mid-transaction and READ_WAIT=4**:
  - Assert reset in cycle 2 of a write -> the next cycle shows all strobes 1, bus released, and no `ack`.
  - With READ_WAIT=4, a read acks in cycle 5.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Host-side request/response bundle for sram_ctrl: single-cycle request strobe
// with address/data, registered read data, completion pulse and busy flag.
interface sram_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_ctrl.sv
// Sequences single-cycle host requests into asynchronous SRAM read/write cycles
// with registered, glitch-free strobes and a tri-state data bus.
module sram_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_SETUP = 1,
  parameter int WRITE_PULSE = 2,
  parameter int WRITE_HOLD  = 1
) (
  input  logic                  clock,
  input  logic                  notReset,
  sram_ctrl_if.slave            host,
  output logic [ADDR_WIDTH-1:0] sramAddr,
  inout  wire  [DATA_WIDTH-1:0] sramData,
  output logic                  sramNotCS,
  output logic                  sramNotOE,
  output logic                  sramNotWE
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_WAIT = max2(max2(READ_WAIT, WRITE_SETUP), max2(WRITE_PULSE, WRITE_HOLD));
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  accept;
  logic                  cs_nxt, oe_nxt, we_nxt, drive_nxt;
  logic                  drive;
  logic [DATA_WIDTH-1:0] wdata_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (host.req) begin
          accept = 1'b1;
          if (host.we) begin
            state_nxt = WR_SETUP;
            cnt_nxt   = CNT_W'(WRITE_SETUP - 1);
          end else begin
            state_nxt = RD;
            cnt_nxt   = CNT_W'(READ_WAIT - 1);
          end
        end
      end
      RD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      WR_SETUP: begin
        if (cnt == '0) begin
          state_nxt = WR_PULSE;
          cnt_nxt   = CNT_W'(WRITE_PULSE - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          state_nxt = WR_HOLD;
          cnt_nxt   = CNT_W'(WRITE_HOLD - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WR_HOLD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Strobes are decoded from the next state so they can be registered
    // and still line up with the state they belong to.
    cs_nxt    = (state_nxt == IDLE);
    oe_nxt    = (state_nxt != RD);
    we_nxt    = (state_nxt != WR_PULSE);
    drive_nxt = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
  end

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state      <= IDLE;
      cnt        <= '0;
      sramNotCS  <= 1'b1;
      sramNotOE  <= 1'b1;
      sramNotWE  <= 1'b1;
      drive      <= 1'b0;
      sramAddr   <= '0;
      host.rdata <= '0;
      host.ack   <= 1'b0;
      host.busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sramNotCS <= cs_nxt;
      sramNotOE <= oe_nxt;
      sramNotWE <= we_nxt;
      drive     <= drive_nxt;
      host.ack  <= (state != IDLE) && (state_nxt == IDLE);
      host.busy <= (state_nxt != IDLE);
      if (accept) sramAddr <= host.addr;
      if (state == RD && cnt == '0) host.rdata <= sramData;
    end
  end

  // Write data needs no reset: it only reaches the pins while drive is set.
  always_ff @(posedge clock) begin
    if (accept) wdata_q <= host.wdata;
  end

  assign sramData = drive ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised bench for sram_ctrl: two instances (default timing and READ_WAIT=4),
// behavioural SRAM models on the pins, and an expected-memory reference model.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int RW = 2;

  logic clock = 1'b0;
  logic notReset = 1'b0;
  logic preload = 1'b1;
  always #5 clock = ~clock;

  sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus4 ();

  logic [AW-1:0] sramAddr, sramAddr4;
  wire  [DW-1:0] sramData, sramData4;
  logic cs, oe, wen, cs4, oe4, wen4;

  sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .notReset(notReset), .host(bus),
    .sramAddr(sramAddr), .sramData(sramData),
    .sramNotCS(cs), .sramNotOE(oe), .sramNotWE(wen)
  );

  sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_WAIT(4)) dut4 (
    .clock(clock), .notReset(notReset), .host(bus4),
    .sramAddr(sramAddr4), .sramData(sramData4),
    .sramNotCS(cs4), .sramNotOE(oe4), .sramNotWE(wen4)
  );

  function automatic logic [15:0] memfile_word(input logic [7:0] a);
    return {a ^ 8'h3C, ~a};
  endfunction

  // Released bus reads as zero through the pulldowns.
  for (genvar i = 0; i < DW; i++) begin : g_pd
    pulldown (sramData[i]);
    pulldown (sramData4[i]);
  end

  logic [15:0] mem [256];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= memfile_word(8'(i));
    end else if (!cs && !wen) begin
      mem[sramAddr] <= sramData;
    end
  end
  assign sramData  = (!cs && !oe)   ? mem[sramAddr] : 16'bz;
  assign sramData4 = (!cs4 && !oe4) ? memfile_word(sramAddr4) : 16'bz;

  logic [15:0] exp_mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // Issues one request in the current cycle and checks every cycle up to the ack.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [15:0] d);
    int last;
    logic [4:0] exp_sig, got_sig;
    last = w ? (S + P + H + 1) : (RW + 1);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    for (int c = 1; c <= last; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin
        bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = 8'($urandom); bus.wdata = 16'($urandom);
      end
      got_sig = {cs, oe, wen, bus.busy, bus.ack};
      if (c < last) exp_sig = {1'b0, w, (w && c > S && c <= S + P) ? 1'b0 : 1'b1, 1'b1, 1'b0};
      else          exp_sig = 5'b11101;
      n_cmp++;
      if (got_sig !== exp_sig) begin
        n_bad++;
        $display("FAIL strobes(%s a=%h c=%0d): got %b expected %b", w ? "wr" : "rd", a, c, got_sig, exp_sig);
      end
      if (c < last) begin
        n_cmp++;
        if (sramAddr !== a) begin
          n_bad++;
          $display("FAIL addr c=%0d: got %h expected %h", c, sramAddr, a);
        end
        n_cmp++;
        if (sramData !== (w ? d : exp_mem[a])) begin
          n_bad++;
          $display("FAIL bus c=%0d: got %h expected %h", c, sramData, w ? d : exp_mem[a]);
        end
      end else begin
        n_cmp++;
        if (sramData !== 16'h0) begin
          n_bad++;
          $display("FAIL bus_release: got %h expected 0000", sramData);
        end
        if (!w) begin
          n_cmp++;
          if (bus.rdata !== exp_mem[a]) begin
            n_bad++;
            $display("FAIL rdata a=%h: got %h expected %h", a, bus.rdata, exp_mem[a]);
          end
        end
      end
    end
    if (w) exp_mem[a] = d;
  endtask

  task automatic test_reset;
    notReset = 1'b0; preload = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = memfile_word(8'(i));
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({cs, oe, wen, bus.busy, bus.ack} !== 5'b11100 || sramData !== 16'h0 || sramAddr !== 8'h0 || bus.rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL reset: got strobes %b bus %h addr %h rdata %h expected 11100 0000 00 0000",
               {cs, oe, wen, bus.busy, bus.ack}, sramData, sramAddr, bus.rdata);
    end
    n_cmp++;
    if ({cs4, oe4, wen4, bus4.busy, bus4.ack} !== 5'b11100 || bus4.rdata !== 16'h0 || sramAddr4 !== 8'h0) begin
      n_bad++;
      $display("FAIL reset4: got strobes %b rdata %h addr %h expected 11100 0000 00",
               {cs4, oe4, wen4, bus4.busy, bus4.ack}, bus4.rdata, sramAddr4);
    end
    notReset = 1'b1; preload = 1'b0;
    idle(1);
  endtask

  task automatic test_single_write;
    run_txn(1'b1, 8'h03, 16'h1234);
    idle(1);
  endtask

  task automatic test_readback;
    run_txn(1'b0, 8'h03, 16'h0);
    n_cmp++;
    if (bus.rdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL readback03: got %h expected 1234", bus.rdata);
    end
    idle(1);
    run_txn(1'b0, 8'h00, 16'h0);
    n_cmp++;
    if (bus.rdata !== memfile_word(8'h00)) begin
      n_bad++;
      $display("FAIL readback00: got %h expected %h", bus.rdata, memfile_word(8'h00));
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    for (int a = 3; a <= 10; a++) run_txn(1'b1, 8'(a), 16'(a) ^ 16'hA5A5);
    for (int a = 3; a <= 10; a++) run_txn(1'b0, 8'(a), 16'h0);
    idle(1);
  endtask

  task automatic test_ignored;
    int acks, oe_low, ack_cyc;
    logic [15:0] d;
    acks = 0; oe_low = 0; ack_cyc = 0;
    d = 16'($urandom) | 16'h0001;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h20; bus.wdata = d;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      if (c == 1) bus.req = 1'b0;
      if (c == 2) begin bus.req = 1'b1; bus.we = 1'b0; bus.addr = 8'h05; end
      if (c == 3) bus.req = 1'b0;
      if (bus.ack === 1'b1) begin acks++; ack_cyc = c; end
      if (oe === 1'b0) oe_low++;
    end
    exp_mem[8'h20] = d;
    n_cmp++;
    if (acks != 1 || ack_cyc != S + P + H + 1) begin
      n_bad++;
      $display("FAIL ignored_ack: got %0d acks last at %0d expected 1 at %0d", acks, ack_cyc, S + P + H + 1);
    end
    n_cmp++;
    if (oe_low != 0) begin
      n_bad++;
      $display("FAIL ignored_rd: got %0d OE-low cycles expected 0", oe_low);
    end
    run_txn(1'b0, 8'h20, 16'h0);
    idle(1);
  endtask

  task automatic test_reset_mid;
    int acks;
    acks = 0;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h40; bus.wdata = 16'hBEEF;
    idle(1);
    bus.req = 1'b0;
    idle(1);
    notReset = 1'b0;
    idle(1);
    n_cmp++;
    if ({cs, oe, wen, bus.busy, bus.ack} !== 5'b11100 || sramData !== 16'h0 || sramAddr !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got strobes %b bus %h addr %h expected 11100 0000 00",
               {cs, oe, wen, bus.busy, bus.ack}, sramData, sramAddr);
    end
    notReset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      idle(1);
      if (bus.ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_bad++;
      $display("FAIL reset_mid_ack: got %0d acks expected 0", acks);
    end
  endtask

  task automatic test_read_wait4;
    int oe_low, first_oe, ack_cyc, we_low;
    logic [7:0] a;
    logic [15:0] got;
    oe_low = 0; first_oe = 0; ack_cyc = 0; we_low = 0; got = 16'h0;
    a = 8'($urandom);
    bus4.req = 1'b1; bus4.we = 1'b0; bus4.addr = a; bus4.wdata = 16'h0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (c == 1) bus4.req = 1'b0;
      if (oe4 === 1'b0) begin
        oe_low++;
        if (first_oe == 0) first_oe = c;
      end
      if (wen4 !== 1'b1) we_low++;
      if (bus4.ack === 1'b1 && ack_cyc == 0) begin ack_cyc = c; got = bus4.rdata; end
    end
    n_cmp++;
    if (ack_cyc != 5 || got !== memfile_word(a)) begin
      n_bad++;
      $display("FAIL rw4_ack: got cycle %0d data %h expected cycle 5 data %h", ack_cyc, got, memfile_word(a));
    end
    n_cmp++;
    if (oe_low != 4 || first_oe != 1 || we_low != 0) begin
      n_bad++;
      $display("FAIL rw4_oe: got %0d OE-low from %0d, %0d WE-low expected 4 from 1, 0", oe_low, first_oe, we_low);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), 8'($urandom_range(0, 63)), 16'($urandom));
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus4.req = 1'b0; bus4.we = 1'b0; bus4.addr = '0; bus4.wdata = '0;
    test_reset();
    test_single_write();
    test_readback();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_read_wait4();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
